// File: rtl/fg_prog_pkg.sv
// Shared encodings for the floating-gate programming sequencer: FSM states,
// response status codes and the cycle-timer width helper.
package fg_prog_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_PULSE   = 3'd2,
    S_GAP     = 3'd3,
    S_RELEASE = 3'd4,
    S_RESP    = 3'd5
  } fg_state_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BAD_ROW = 2'd1,
    ST_ABORTED = 2'd2
  } fg_status_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit so the largest reload value always fits.
  function automatic int tmr_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/fg_prog_timer.sv
// Loadable down-counter; zero is high once the count has run out and it
// parks there until the next load.
module fg_prog_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fg_prog_sequencer.sv
// Drives one floating-gate programming operation: settle the switches, issue
// a train of injection pulses, release, then report status and pulse count.
module fg_prog_sequencer #(
  parameter int NUM_ROWS   = 10,
  parameter int ADDR_BITS  = 6,
  parameter int SETTLE_CYC = 16,
  parameter int PULSE_CYC  = 100,
  parameter int GAP_CYC    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_row,
  input  logic [ADDR_BITS-1:0] cmd_col,
  input  logic [7:0]           cmd_pulses,
  input  logic                 abort,
  output logic [ADDR_BITS-1:0] dec_addr,
  output logic                 dec_en,
  output logic [NUM_ROWS-1:0]  drain_sel,
  output logic                 prog_sw_en,
  output logic                 vinj_pulse,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_status,
  output logic [7:0]           rsp_count
);
  import fg_prog_pkg::*;

  localparam int            TW        = tmr_width(SETTLE_CYC, PULSE_CYC, GAP_CYC);
  localparam logic [4:0]    ROW_LIM   = 5'(NUM_ROWS);
  localparam logic [TW-1:0] LD_SETTLE = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] LD_PULSE  = TW'(PULSE_CYC - 1);
  localparam logic [TW-1:0] LD_GAP    = TW'(GAP_CYC - 1);

  fg_state_e              state, nxt;
  logic [3:0]             row_r, row_n;
  logic [ADDR_BITS-1:0]   col_r, col_n;
  logic [7:0]             pulses_r;
  logic [7:0]             issued_r, issued_n;
  fg_status_e             status_r, status_n;
  logic                   accept, take_abort, inc;
  logic                   tmr_load, tmr_zero;
  logic [TW-1:0]          tmr_val;
  logic [NUM_ROWS-1:0]    sel_n;
  logic                   active_n, sw_n;

  fg_prog_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Abort is checked ahead of timer expiry so an abort on a pulse's last
  // cycle does not count that pulse as issued.
  always_comb begin
    nxt        = state;
    accept     = 1'b0;
    take_abort = 1'b0;
    inc        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept = 1'b1;
          nxt    = ({1'b0, cmd_row} >= ROW_LIM) ? S_RESP : S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          take_abort = 1'b1;
          nxt        = S_RELEASE;
        end else if (tmr_zero) begin
          nxt = (pulses_r == 8'd0) ? S_RELEASE : S_PULSE;
        end
      end
      S_PULSE: begin
        if (abort) begin
          take_abort = 1'b1;
          nxt        = S_RELEASE;
        end else if (tmr_zero) begin
          inc = 1'b1;
          nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (abort) begin
          take_abort = 1'b1;
          nxt        = S_RELEASE;
        end else if (tmr_zero) begin
          nxt = (issued_r < pulses_r) ? S_PULSE : S_RELEASE;
        end
      end
      S_RELEASE: if (tmr_zero) nxt = S_RESP;
      S_RESP:    if (rsp_ready) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    row_n    = accept ? cmd_row : row_r;
    col_n    = accept ? cmd_col : col_r;
    issued_n = accept ? 8'd0 : issued_r + {7'd0, inc};
    if (accept)
      status_n = (nxt == S_RESP) ? ST_BAD_ROW : ST_OK;
    else if (take_abort)
      status_n = ST_ABORTED;
    else
      status_n = status_r;
  end

  // Timer reloads on every state entry with the length of the state entered.
  always_comb begin
    tmr_load = (nxt != state);
    tmr_val  = '0;
    case (nxt)
      S_SETUP, S_RELEASE: tmr_val = LD_SETTLE;
      S_PULSE:            tmr_val = LD_PULSE;
      S_GAP:              tmr_val = LD_GAP;
      default:            tmr_val = '0;
    endcase
  end

  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NUM_ROWS; i++) sel_n[i] = (row_n == 4'(i));
  end

  assign active_n = (nxt == S_SETUP) || (nxt == S_PULSE) ||
                    (nxt == S_GAP)   || (nxt == S_RELEASE);
  assign sw_n     = (nxt == S_SETUP) || (nxt == S_PULSE) || (nxt == S_GAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      row_r    <= '0;
      col_r    <= '0;
      pulses_r <= '0;
      issued_r <= '0;
      status_r <= ST_OK;
    end else begin
      state    <= nxt;
      row_r    <= row_n;
      col_r    <= col_n;
      issued_r <= issued_n;
      status_r <= status_n;
      if (accept) pulses_r <= cmd_pulses;
    end
  end

  // Outputs are registered from the next state so they line up exactly with
  // the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready  <= 1'b0;
      dec_addr   <= '0;
      dec_en     <= 1'b0;
      drain_sel  <= '0;
      prog_sw_en <= 1'b0;
      vinj_pulse <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= 2'd0;
      rsp_count  <= 8'd0;
    end else begin
      cmd_ready  <= (nxt == S_IDLE);
      dec_addr   <= active_n ? col_n : '0;
      dec_en     <= active_n;
      drain_sel  <= active_n ? sel_n : '0;
      prog_sw_en <= sw_n;
      vinj_pulse <= (nxt == S_PULSE);
      rsp_valid  <= (nxt == S_RESP);
      rsp_status <= (nxt == S_RESP) ? status_n : ST_OK;
      rsp_count  <= (nxt == S_RESP) ? issued_n : 8'd0;
    end
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Directed bench for fg_prog_sequencer: a timeline model predicts every output
// cycle by cycle, directed tests pin pulse widths, gaps and response values.
module tb_fg_prog_sequencer;

  localparam int NUM_ROWS  = 10;
  localparam int ADDR_BITS = 6;
  localparam int SETTLE    = 16;
  localparam int PULSE     = 100;
  localparam int GAP       = 8;
  localparam int P_SET = 1, P_PUL = 2, P_GAP = 3, P_REL = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [3:0]           cmd_row = '0;
  logic [ADDR_BITS-1:0] cmd_col = '0;
  logic [7:0]           cmd_pulses = '0;
  logic                 abort = 1'b0;
  logic [ADDR_BITS-1:0] dec_addr;
  logic                 dec_en;
  logic [NUM_ROWS-1:0]  drain_sel;
  logic                 prog_sw_en;
  logic                 vinj_pulse;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [1:0]           rsp_status;
  logic [7:0]           rsp_count;

  int checks = 0;
  int failures = 0;
  int vinj_cyc = 0;
  bit cmp_en = 1'b0;

  fg_prog_sequencer #(
    .NUM_ROWS(NUM_ROWS), .ADDR_BITS(ADDR_BITS),
    .SETTLE_CYC(SETTLE), .PULSE_CYC(PULSE), .GAP_CYC(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_pulses(cmd_pulses),
    .abort(abort),
    .dec_addr(dec_addr), .dec_en(dec_en), .drain_sel(drain_sel),
    .prog_sw_en(prog_sw_en), .vinj_pulse(vinj_pulse),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 50)
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted command expands into a per-cycle phase timeline.
  int  tl[$];
  int  cur = 0;
  int  mmode = 0;      // 0 idle, 1 busy, 2 responding
  bit  m_rdy = 1'b0;
  int  m_row = 0, m_col = 0, m_cnt = 0, m_st = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      tl.delete();
      cur = 0; mmode = 0; m_rdy = 1'b0; m_row = 0; m_col = 0; m_cnt = 0; m_st = 0;
    end else begin
      case (mmode)
        0: if (m_rdy && cmd_valid) begin
          m_row = int'(cmd_row); m_col = int'(cmd_col); m_cnt = 0;
          if (int'(cmd_row) >= NUM_ROWS) begin
            mmode = 2; m_st = 1;
          end else begin
            tl.delete();
            repeat (SETTLE) tl.push_back(P_SET);
            repeat (int'(cmd_pulses)) begin
              repeat (PULSE) tl.push_back(P_PUL);
              repeat (GAP)   tl.push_back(P_GAP);
            end
            repeat (SETTLE) tl.push_back(P_REL);
            m_st = 0; mmode = 1; cur = tl.pop_front();
          end
        end
        1: begin
          if (abort && cur != P_REL) begin
            while (tl.size() > 0 && tl[0] != P_REL) void'(tl.pop_front());
            m_st = 2;
          end else if (cur == P_PUL && tl.size() > 0 && tl[0] == P_GAP) begin
            m_cnt++;
          end
          if (tl.size() == 0) mmode = 2;
          else cur = tl.pop_front();
        end
        default: if (rsp_ready) mmode = 0;
      endcase
      m_rdy = (mmode == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      logic [NUM_ROWS-1:0] e_sel;
      e_sel = (mmode == 1) ? (NUM_ROWS'(1) << m_row) : '0;
      chk("cyc_cmd_ready", cmd_ready, m_rdy);
      chk("cyc_dec_en", dec_en, mmode == 1);
      chk("cyc_dec_addr", dec_addr, (mmode == 1) ? m_col : 0);
      chk("cyc_drain_sel", drain_sel, e_sel);
      chk("cyc_prog_sw_en", prog_sw_en, (mmode == 1) && (cur != P_REL));
      chk("cyc_vinj_pulse", vinj_pulse, (mmode == 1) && (cur == P_PUL));
      chk("cyc_rsp_valid", rsp_valid, mmode == 2);
      chk("cyc_rsp_status", rsp_status, (mmode == 2) ? m_st : 0);
      chk("cyc_rsp_count", rsp_count, (mmode == 2) ? m_cnt : 0);
    end
  end

  initial forever begin
    @(posedge clk);
    #1 if (vinj_pulse) vinj_cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return vinj_pulse;
      1:       return prog_sw_en;
      default: return rsp_valid;
    endcase
  endfunction

  task automatic run_len(input int sel, input logic val, output int n);
    n = 0;
    while (sig_of(sel) === val && n < 5000) begin
      n++;
      @(negedge clk);
    end
    chk("run_bound", n < 5000, 1);
  endtask

  task automatic send(input int row, input int col, input int np);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_row = 4'(row); cmd_col = ADDR_BITS'(col); cmd_pulses = 8'(np);
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", n < 300, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int n, v0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_outputs", {dec_en, drain_sel, prog_sw_en, vinj_pulse, rsp_valid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_after", cmd_ready, 1);

    // Two pulses on row 3
    v0 = vinj_cyc;
    send(3, 'h15, 2);
    @(negedge clk);
    chk("A_drain_sel", drain_sel, 10'h008);
    chk("A_dec_addr", dec_addr, 'h15);
    chk("A_sw_en", prog_sw_en, 1);
    run_len(0, 1'b0, n); chk("A_setup_len", n, 16);
    run_len(0, 1'b1, n); chk("A_pulse1_len", n, 100);
    run_len(0, 1'b0, n); chk("A_gap_len", n, 8);
    run_len(0, 1'b1, n); chk("A_pulse2_len", n, 100);
    run_len(2, 1'b0, n); chk("A_tail_len", n, 24);
    chk("A_status", rsp_status, 0);
    chk("A_count", rsp_count, 2);
    chk("A_vinj_total", vinj_cyc - v0, 200);
    take_rsp();

    // Out-of-range row
    v0 = vinj_cyc;
    send(10, 'h2A, 3);
    @(negedge clk);
    chk("B_rsp_valid", rsp_valid, 1);
    chk("B_status", rsp_status, 1);
    chk("B_count", rsp_count, 0);
    chk("B_quiet", {dec_en, drain_sel, prog_sw_en}, 0);
    take_rsp();
    chk("B_no_vinj", vinj_cyc - v0, 0);

    // Zero pulses
    v0 = vinj_cyc;
    send(7, 9, 0);
    @(negedge clk);
    run_len(1, 1'b1, n); chk("C_setup_len", n, 16);
    run_len(2, 1'b0, n); chk("C_release_len", n, 16);
    chk("C_status", rsp_status, 0);
    chk("C_count", rsp_count, 0);
    chk("C_no_vinj", vinj_cyc - v0, 0);
    take_rsp();

    // Abort at cycle 50 of the second pulse
    send(4, 'h30, 5);
    @(negedge clk);
    run_len(0, 1'b0, n); chk("D_setup_len", n, 16);
    run_len(0, 1'b1, n); chk("D_pulse1_len", n, 100);
    run_len(0, 1'b0, n); chk("D_gap_len", n, 8);
    repeat (49) @(negedge clk);
    chk("D_pre_abort", vinj_pulse, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("D_vinj_drop", vinj_pulse, 0);
    chk("D_sw_drop", prog_sw_en, 0);
    chk("D_dec_held", dec_en, 1);
    run_len(2, 1'b0, n); chk("D_release_len", n, 16);
    chk("D_status", rsp_status, 2);
    chk("D_count", rsp_count, 1);
    take_rsp();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("D_idle_abort", cmd_ready, 1);

    // Stalled response, then back-to-back command
    send(0, 'h3F, 1);
    @(negedge clk);
    run_len(2, 1'b0, n); chk("E_busy_len", n, 140);
    cmd_valid = 1'b1; cmd_row = 4'd9; cmd_col = 6'd1; cmd_pulses = 8'd1;
    repeat (20) begin
      chk("E_hold_valid", rsp_valid, 1);
      chk("E_hold_count", rsp_count, 1);
      chk("E_hold_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("E_idle_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("E_b2b_accept", cmd_ready, 0);
    chk("E_b2b_sel", drain_sel, 10'h200);
    run_len(2, 1'b0, n); chk("E_b2b_len", n, 140);
    chk("E_b2b_count", rsp_count, 1);
    take_rsp();

    // Reset in the middle of a pulse
    send(5, 7, 3);
    @(negedge clk);
    run_len(0, 1'b0, n); chk("F_setup_len", n, 16);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("F_async_vinj", vinj_pulse, 0);
    chk("F_async_outs", {cmd_ready, dec_en, drain_sel, prog_sw_en, rsp_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2, 'h2A, 1);
    @(negedge clk);
    chk("F_after_sel", drain_sel, 10'h004);
    run_len(2, 1'b0, n); chk("F_after_len", n, 140);
    chk("F_after_status", rsp_status, 0);
    chk("F_after_count", rsp_count, 1);
    take_rsp();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fg_prog_sequencer.md
FG_PROG_SEQUENCER -- requirements
Module: fg_prog_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 10: number of drain-select rows in the island.
REQ-002 SHALL have parameter ADDR_BITS, default 6: width of the column address driven to the vertical injection decoder.
REQ-003 SHALL have parameters SETTLE_CYC 16, PULSE_CYC 100, GAP_CYC 8: switch-settle, injection-pulse and inter-pulse cycle counts (all >=1).
REQ-004 SHALL have port clk, input, 1: single clock.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1: command offered.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid&&cmd_ready.
REQ-008 SHALL have port cmd_row, input, 4: target drain row.
REQ-009 SHALL have port cmd_col, input, ADDR_BITS: target decoder address.
REQ-010 SHALL have port cmd_pulses, input, 8: number of injection pulses.
REQ-011 SHALL have port abort, input, 1: terminate current operation.
REQ-012 SHALL have port dec_addr, output, ADDR_BITS: decoder address.
REQ-013 SHALL have port dec_en, output, 1: decoder enable.
REQ-014 SHALL have port drain_sel, output, NUM_ROWS: one-hot drain select.
REQ-015 SHALL have port prog_sw_en, output, 1: programming-switch (draincutoff TGate) enable.
REQ-016 SHALL have port vinj_pulse, output, 1: injection pulse strobe.
REQ-017 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_status output 2 (0 OK, 1 BAD_ROW, 2 ABORTED), rsp_count output 8 (pulses actually issued).

Function
REQ-018 SHALL implement states IDLE, SETUP, PULSE, GAP, RELEASE, RESP.
REQ-019 SHALL assert cmd_ready only in IDLE; handshake moves IDLE->SETUP and latches row, col, pulses; pulse counter cleared.
REQ-020 SHALL, if latched cmd_row >= NUM_ROWS, go IDLE->RESP directly with status BAD_ROW, count 0, never asserting dec_en, drain_sel, prog_sw_en or vinj_pulse.
REQ-021 SHALL in SETUP drive dec_addr=col, dec_en=1, drain_sel one-hot at row, prog_sw_en=1 for exactly SETTLE_CYC cycles, then go PULSE, or RELEASE if pulses==0.
REQ-022 SHALL hold vinj_pulse=1 for exactly PULSE_CYC cycles in PULSE and 0 in every other state; issued count increments on PULSE exit.
REQ-023 SHALL hold GAP for exactly GAP_CYC cycles, then go PULSE if issued<pulses, else RELEASE.
REQ-024 SHALL in RELEASE drive prog_sw_en=0, vinj_pulse=0 while keeping dec_en/drain_sel for SETTLE_CYC cycles, then clear dec_en, drain_sel, dec_addr and go RESP.
REQ-025 SHALL in RESP assert rsp_valid with stable status/count until rsp_ready, then return to IDLE; rsp_ready and cmd_valid ignored elsewhere.
REQ-026 SHALL on abort in SETUP, PULSE or GAP go RELEASE next cycle (vinj_pulse drops that edge), final status ABORTED; abort in IDLE, RELEASE or RESP has no effect.
REQ-027 SHALL never have vinj_pulse=1 unless prog_sw_en=1 and drain_sel nonzero; drain_sel SHALL never be multi-hot.
REQ-028 SHALL make all outputs registered; a single cycle counter, width clog2(max parameter)+1, reloads on each state entry.

Reset
REQ-029 SHALL on rst_n low immediately set state IDLE and all outputs 0 except cmd_ready, which becomes 1 after rst_n deasserts; reset mid-pulse drops vinj_pulse asynchronously with no response issued.

Structure
REQ-030 SHALL place state enum and rsp_status encodings in shared package fg_prog_pkg.
REQ-031 SHALL contain no sub-modules other than optional fg_prog_timer (loadable down-counter with zero flag).

Verification
REQ-032 Bench SHALL cover: row 3, col 0x15, pulses 2 -> drain_sel=0x008, two 100-cycle vinj_pulse separated by 8 cycles, rsp OK count 2.
REQ-033 Bench SHALL cover: row 10 -> rsp BAD_ROW count 0 within 2 cycles, outputs stay 0.
REQ-034 Bench SHALL cover: pulses 0 -> 16 SETUP + 16 RELEASE cycles, no vinj_pulse, rsp OK count 0.
REQ-035 Bench SHALL cover: pulses 5, abort at cycle 50 of pulse 2 -> vinj_pulse low next edge, rsp ABORTED count 1.
REQ-036 Bench SHALL cover: rsp_ready held low 20 cycles -> rsp stable, cmd_ready stays 0; then back-to-back command accepted the cycle after handshake.
REQ-037 Bench SHALL cover: rst_n pulsed during PULSE -> all outputs 0 asynchronously, next command completes normally.
